fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- pulls bytes from an upstream FIFO and serialises them as
// 8N1 UART frames (8E1 when FIFO_UART_TX_PARITY_EN is defined).
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits (11-bit frame)
//   undefined -> no parity state or logic (10-bit frame)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous active-high reset
//   FIFO_DATA   byte presented by the upstream FIFO (valid one cycle after RD_EN)
//   FIFO_EMPTY  upstream FIFO empty flag
//   FIFO_RD_EN  registered one-cycle read strobe to the upstream FIFO
//   TX          serial line, idle high
//   BUSY        high in every state except IDLE
//   BYTE_DONE   one-cycle pulse in the last cycle of the stop bit
//
// Every output is a register that is loaded on the same edge as the state it
// belongs to, so each output always describes the state currently held.

module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] FIFO_DATA,
    input  logic       FIFO_EMPTY,
    output logic       FIFO_RD_EN,
    output logic       TX,
    output logic       BUSY,
    output logic       BYTE_DONE
);

    // Last count of a bit period, and the count one before it (used to raise
    // BYTE_DONE so that the registered pulse lands on the final stop cycle).
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Aborts any frame in flight; a byte already popped is dropped.
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            TX         <= 1'b1;
            FIFO_RD_EN <= 1'b0;
            BUSY       <= 1'b0;
            BYTE_DONE  <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            FIFO_RD_EN <= 1'b0;
            BYTE_DONE  <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    TX       <= 1'b1;
                    if (!FIFO_EMPTY) begin
                        state      <= READ;
                        FIFO_RD_EN <= 1'b1;
                        BUSY       <= 1'b1;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end

                READ: begin
                    // Strobe was issued on entry; the FIFO returns data
                    // during the following cycle.
                    state    <= LATCH;
                    baud_cnt <= '0;
                end

                LATCH: begin
                    // Only point at which FIFO_DATA is looked at; the byte is
                    // frozen for the rest of the frame.
                    shreg    <= FIFO_DATA;
                    state    <= START;
                    baud_cnt <= '0;
                    TX       <= 1'b0;
                end

                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        TX       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            state   <= PARITY;
                            TX      <= ^shreg;
`else
                            state   <= STOP;
                            TX      <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TX      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        TX       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        BUSY     <= 1'b0;
                    end else begin
                        baud_cnt  <= baud_cnt + 16'd1;
                        // Registered one cycle early so the pulse coincides
                        // with the final stop cycle.
                        BYTE_DONE <= (baud_cnt == BAUD_PRE);
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    TX       <= 1'b1;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: an upstream FIFO model with one-cycle read latency,
// a frame-position reference model, a line decoder and directed + random runs.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycles a frame occupies from the READ cycle to the last stop cycle.
    localparam int FLEN = 2 + NBITS * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] FIFO_DATA = 8'h00;
    logic       FIFO_EMPTY = 1'b1;
    logic       FIFO_RD_EN, TX, BUSY, BYTE_DONE;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RD_EN(FIFO_RD_EN), .TX(TX), .BUSY(BUSY), .BYTE_DONE(BYTE_DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0;
    logic [7:0] fq[$];        // upstream FIFO contents
    logic [7:0] pend[$];      // bytes to push at the next stimulus point
    logic [7:0] sent[$];      // bytes decoded from the line at each BYTE_DONE
    logic       par_log[$];   // parity bit decoded per frame
    logic       tx_log[$];    // TX sampled every cycle, index = cyc
    int  m_phase = -1;        // model: cycles since READ, -1 when idle
    logic [7:0] m_byte = 8'h00;
    int  push_pct = 0, scramble = 0;
    bit  rst_req = 1'b1, gap_chk = 1'b0, arm = 1'b0;
    int  t_rd = -1, t_fall = -1, t_done = -1000, t_bfall = -1, test_start = 0;
    int  n_rd = 0, n_done = 0;
    logic prev_busy = 1'b0;
    logic [7:0] last_popped = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model of the line level at frame position p: start, 8 data LSB first,
    // optional even parity, stop.
    function automatic logic m_tx_bit(input int p, input logic [7:0] b);
        int k;
        if (p < 2) return 1'b1;
        k = (p - 2) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // One clock: compare at negedge, react as the FIFO, drive next inputs,
    // then advance the model to what the coming edge must produce.
    task automatic cycle();
        logic e_tx, e_rd, e_busy, e_done;
        logic [7:0] dec;
        @(negedge CLK);
        e_rd   = (m_phase == 0);
        e_busy = (m_phase >= 0);
        e_tx   = (m_phase < 0) ? 1'b1 : m_tx_bit(m_phase, m_byte);
        e_done = (m_phase == FLEN - 1);
        chk("tx", int'(TX), int'(e_tx));
        chk("rd_en", int'(FIFO_RD_EN), int'(e_rd));
        chk("busy", int'(BUSY), int'(e_busy));
        chk("byte_done", int'(BYTE_DONE), int'(e_done));
        tx_log.push_back(TX);

        if (FIFO_RD_EN) begin
            n_rd++;
            t_rd = cyc;
            arm  = 1'b1;
            chk("underflow", int'(fq.size() == 0), 0);
            if (fq.size() != 0) begin
                FIFO_DATA   = fq.pop_front();
                last_popped = FIFO_DATA;
            end
        end
        if (arm && !TX) begin
            arm = 1'b0;
            if (gap_chk && t_done >= test_start) chk("gap", cyc - t_done, 4);
            t_fall = cyc;
        end
        if (prev_busy && !BUSY) t_bfall = cyc;
        prev_busy = BUSY;
        if (BYTE_DONE) begin
            n_done++;
            t_done = cyc;
            dec = 8'h00;
            if (t_fall >= 0)
                for (int i = 0; i < 8; i++) dec[i] = tx_log[t_fall + CPB * (1 + i) + CPB / 2];
            sent.push_back(dec);
            chk("byte", int'(dec), int'(last_popped));
            if (NBITS == 11 && t_fall >= 0) begin
                par_log.push_back(tx_log[t_fall + CPB * 9 + CPB / 2]);
                chk("parity", int'(tx_log[t_fall + CPB * 9 + CPB / 2]), int'(^dec));
            end
        end

        while (pend.size() != 0) fq.push_back(pend.pop_front());
        if (push_pct > 0 && $urandom_range(99) < push_pct) fq.push_back(8'($urandom));
        if (scramble == 1 && m_phase >= 2) FIFO_DATA = 8'h00;
        if (scramble == 2 && m_phase >= 2) FIFO_DATA = 8'($urandom);
        RST = rst_req;
        FIFO_EMPTY = (fq.size() == 0);

        if (rst_req) m_phase = -1;
        else if (m_phase < 0) begin
            if (!FIFO_EMPTY) m_phase = 0;
        end else begin
            if (m_phase == 1) m_byte = FIFO_DATA;
            m_phase++;
            if (m_phase == FLEN) m_phase = -1;
        end
        cyc++;
    endtask

    initial begin
        int rd0, dn0, sb, waited;
        logic [7:0] dec;

        // Reset values
        @(posedge CLK); #1;
        chk("rst_tx", int'(TX), 1);
        chk("rst_rd_en", int'(FIFO_RD_EN), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(BYTE_DONE), 0);
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req = 1'b0;

        // Empty FIFO for 50 cycles: nothing happens
        repeat (50) cycle();
        chk("idle_rd_count", n_rd, 0);
        chk("idle_done_count", n_done, 0);

        // Single byte F0: timing and bit pattern
        test_start = cyc; rd0 = n_rd; dn0 = n_done;
        pend.push_back(8'hF0);
        repeat (60) cycle();
        chk("f0_rd_pulses", n_rd - rd0, 1);
        chk("f0_done_pulses", n_done - dn0, 1);
        chk("f0_fall_after_rd", t_fall - t_rd, 2);
        chk("f0_fall_to_idle", t_bfall - t_fall, (NBITS == 11) ? 44 : 40);
        chk("f0_done_pos", t_done - t_fall, (NBITS == 11) ? 43 : 39);
        dec = 8'h00;
        for (int i = 0; i < 8; i++) dec[i] = tx_log[t_fall + CPB * (1 + i) + CPB / 2];
        chk("f0_bits", int'(dec), 8'hF0);

        // Eight queued bytes back to back
        test_start = cyc; rd0 = n_rd; dn0 = n_done; sb = sent.size();
        for (int i = 0; i < 8; i++) pend.push_back(8'(8'hF0 + i));
        gap_chk = 1'b1;
        repeat (8 * (FLEN + 2) + 20) cycle();
        gap_chk = 1'b0;
        chk("burst_rd_pulses", n_rd - rd0, 8);
        chk("burst_done_pulses", n_done - dn0, 8);
        for (int i = 0; i < 8; i++)
            if (sb + i < sent.size()) chk("burst_order", int'(sent[sb + i]), 8'hF0 + i);

        // Reset during data bit 3 of A5, then 3C must go out cleanly
        dn0 = n_done; sb = sent.size();
        pend.push_back(8'hA5); pend.push_back(8'h3C);
        waited = 0;
        while (m_phase != 2 + CPB * 4 + 1 && waited < 200) begin
            cycle();
            waited++;
        end
        chk("reach_bit3", int'(waited < 200), 1);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        @(posedge CLK); #1;
        chk("abort_tx", int'(TX), 1);
        chk("abort_busy", int'(BUSY), 0);
        repeat (FLEN + 20) cycle();
        chk("abort_done_pulses", n_done - dn0, 1);
        if (sent.size() > sb) chk("after_abort_byte", int'(sent[sb]), 8'h3C);

        // FIFO_DATA forced to 00 mid-frame of F3
        sb = sent.size();
        scramble = 1;
        pend.push_back(8'hF3);
        repeat (FLEN + 20) cycle();
        scramble = 0;
        chk("hold_count", sent.size() - sb, 1);
        if (sent.size() > sb) chk("hold_byte", int'(sent[sb]), 8'hF3);

`ifdef FIFO_UART_TX_PARITY_EN
        sb = par_log.size();
        pend.push_back(8'hF1); pend.push_back(8'hF3);
        repeat (2 * (FLEN + 4) + 10) cycle();
        chk("par_count", par_log.size() - sb, 2);
        if (par_log.size() > sb + 1) begin
            chk("par_f1", int'(par_log[sb]), 1);
            chk("par_f3", int'(par_log[sb + 1]), 0);
        end
`endif

        // Random traffic, data wiggling mid-frame, occasional resets
        scramble = 2;
        for (int blk = 0; blk < 30; blk++) begin
            push_pct = $urandom_range(70);
            repeat (100) begin
                rst_req = ($urandom_range(399) == 0);
                cycle();
            end
        end
        rst_req = 1'b0;
        push_pct = 0;
        scramble = 0;
        repeat (200) cycle();
        while (fq.size() != 0 && waited < 100000) begin
            cycle();
            waited++;
        end
        repeat (FLEN + 10) cycle();
        chk("drained", int'(BUSY), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
